// File: rtl/fft_pkg.sv
// Shared constants, complex-word helpers and saturation for the radix-2 FFT/IFFT butterflies.
// Complex words pack the real part in the upper half and the imaginary part in the lower half.
package fft_pkg;
   localparam int WORD_SIZE = 74;
   localparam int HALF_SIZE = 37;
   localparam int FRAC_BITS = 16;
   localparam int SUM_W     = HALF_SIZE + 1;
   localparam int PROD_W    = 2*HALF_SIZE + 3;
   localparam int STAGES    = 3;

   typedef logic        [WORD_SIZE-1:0] word_t;
   typedef logic signed [HALF_SIZE-1:0] half_t;
   typedef logic signed [SUM_W-1:0]     sum_t;
   typedef logic signed [PROD_W-1:0]    prod_t;

   typedef struct packed {
      logic  clip;
      half_t val;
   } sat_t;

   function automatic half_t cplx_re(word_t w);
      return w[WORD_SIZE-1:HALF_SIZE];
   endfunction

   function automatic half_t cplx_im(word_t w);
      return w[HALF_SIZE-1:0];
   endfunction

   function automatic word_t cplx_pack(half_t re, half_t im);
      return {re, im};
   endfunction

   function automatic sum_t sext1(half_t x);
      return {x[HALF_SIZE-1], x};
   endfunction

   // Exact floor(s/2) of a one-bit-grown sum always fits back into a component.
   function automatic half_t half_floor(sum_t s);
      return half_t'(s >>> 1);
   endfunction

   // In range iff every bit from the component sign bit upward matches.
   function automatic sat_t sat_half(prod_t x);
      sat_t                      r;
      logic [PROD_W-HALF_SIZE:0] top;
      top    = x[PROD_W-1:HALF_SIZE-1];
      r.clip = !((&top) || !(|top));
      if (!r.clip)
         r.val = x[HALF_SIZE-1:0];
      else if (x[PROD_W-1])
         r.val = {1'b1, {(HALF_SIZE-1){1'b0}}};
      else
         r.val = {1'b0, {(HALF_SIZE-1){1'b1}}};
      return r;
   endfunction
endpackage

// File: rtl/ifft_butterfly_if.sv
// Input triple / output pair handshake bundle for the IFFT butterfly.
interface ifft_butterfly_if;
   import fft_pkg::*;

   logic  i_valid;
   logic  o_ready;
   word_t i_A;
   word_t i_B;
   word_t i_twiddle;
   logic  o_valid;
   logic  i_ready;
   word_t o_A;
   word_t o_B;
   logic  o_overflow;

   modport slave (
      input  i_valid, i_A, i_B, i_twiddle, i_ready,
      output o_ready, o_valid, o_A, o_B, o_overflow
   );

   modport master (
      output i_valid, i_A, i_B, i_twiddle, i_ready,
      input  o_ready, o_valid, o_A, o_B, o_overflow
   );
endinterface

// File: rtl/cplx_conj_mult_pipe.sv
// Registered full-precision complex multiply d*conj(w) (or d*w with CONJ=0), one stage, enabled.
module cplx_conj_mult_pipe
   import fft_pkg::*;
#(
   parameter bit CONJ = 1'b1
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  sum_t  dr,
   input  sum_t  di,
   input  half_t wr,
   input  half_t wi,
   output prod_t p_r,
   output prod_t p_i
);
   prod_t dr_x, di_x, wr_x, wi_x;
   prod_t p_r_d, p_r_q, p_i_d, p_i_q;

   always_comb begin
      dr_x  = {{(PROD_W-SUM_W){dr[SUM_W-1]}}, dr};
      di_x  = {{(PROD_W-SUM_W){di[SUM_W-1]}}, di};
      wr_x  = {{(PROD_W-HALF_SIZE){wr[HALF_SIZE-1]}}, wr};
      wi_x  = {{(PROD_W-HALF_SIZE){wi[HALF_SIZE-1]}}, wi};
      p_r_d = p_r_q;
      p_i_d = p_i_q;
      if (en) begin
         if (CONJ) begin
            p_r_d = dr_x*wr_x + di_x*wi_x;
            p_i_d = di_x*wr_x - dr_x*wi_x;
         end else begin
            p_r_d = dr_x*wr_x - di_x*wi_x;
            p_i_d = di_x*wr_x + dr_x*wi_x;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_r_q <= '0;
         p_i_q <= '0;
      end else begin
         p_r_q <= p_r_d;
         p_i_q <= p_i_d;
      end
   end

   assign p_r = p_r_q;
   assign p_i = p_i_q;
endmodule

// File: rtl/ifft_butterfly.sv
// Three-stage Gentleman-Sande inverse butterfly: o_A=(A+B)/2, o_B=(A-B)*conj(W)/2, saturating o_B.
// One global enable stalls every stage together; bubbles travel with the data.
module ifft_butterfly
   import fft_pkg::*;
(
   input logic             i_CLK,
   input logic             i_RST,
   ifft_butterfly_if.slave bus
);
   logic              en, in_xfer;
   logic [STAGES:1]   vld_pipe_d, vld_pipe_q;

   sum_t  s1_sum_r_d, s1_sum_r_q, s1_sum_i_d, s1_sum_i_q;
   sum_t  s1_diff_r_d, s1_diff_r_q, s1_diff_i_d, s1_diff_i_q;
   half_t s1_wr_d, s1_wr_q, s1_wi_d, s1_wi_q;

   sum_t  s2_sum_r_d, s2_sum_r_q, s2_sum_i_d, s2_sum_i_q;
   prod_t s2_p_r, s2_p_i;

   half_t s3_a_r_d, s3_a_r_q, s3_a_i_d, s3_a_i_q;
   half_t s3_b_r_d, s3_b_r_q, s3_b_i_d, s3_b_i_q;
   logic  s3_ovf_d, s3_ovf_q;
   sat_t  sat_r, sat_i;

   assign en      = !vld_pipe_q[STAGES] || bus.i_ready;
   assign in_xfer = bus.i_valid && en;

   always_comb begin
      vld_pipe_d = en ? {vld_pipe_q[STAGES-1:1], in_xfer} : vld_pipe_q;
   end

   always_comb begin
      s1_sum_r_d  = s1_sum_r_q;
      s1_sum_i_d  = s1_sum_i_q;
      s1_diff_r_d = s1_diff_r_q;
      s1_diff_i_d = s1_diff_i_q;
      s1_wr_d     = s1_wr_q;
      s1_wi_d     = s1_wi_q;
      if (en) begin
         s1_sum_r_d  = sext1(cplx_re(bus.i_A)) + sext1(cplx_re(bus.i_B));
         s1_sum_i_d  = sext1(cplx_im(bus.i_A)) + sext1(cplx_im(bus.i_B));
         s1_diff_r_d = sext1(cplx_re(bus.i_A)) - sext1(cplx_re(bus.i_B));
         s1_diff_i_d = sext1(cplx_im(bus.i_A)) - sext1(cplx_im(bus.i_B));
         s1_wr_d     = cplx_re(bus.i_twiddle);
         s1_wi_d     = cplx_im(bus.i_twiddle);
      end
   end

   // Sum rides through S2 untouched so it lines up with the product.
   always_comb begin
      s2_sum_r_d = en ? s1_sum_r_q : s2_sum_r_q;
      s2_sum_i_d = en ? s1_sum_i_q : s2_sum_i_q;
   end

   cplx_conj_mult_pipe #(.CONJ(1'b1)) u_mult (
      .clk (i_CLK),
      .rst (i_RST),
      .en  (en),
      .dr  (s1_diff_r_q),
      .di  (s1_diff_i_q),
      .wr  (s1_wr_q),
      .wi  (s1_wi_q),
      .p_r (s2_p_r),
      .p_i (s2_p_i)
   );

   // Extra bit in the shift folds the per-stage 1/2 into the twiddle descale.
   always_comb begin
      sat_r    = sat_half(s2_p_r >>> (FRAC_BITS+1));
      sat_i    = sat_half(s2_p_i >>> (FRAC_BITS+1));
      s3_a_r_d = s3_a_r_q;
      s3_a_i_d = s3_a_i_q;
      s3_b_r_d = s3_b_r_q;
      s3_b_i_d = s3_b_i_q;
      s3_ovf_d = s3_ovf_q;
      if (en) begin
         s3_a_r_d = half_floor(s2_sum_r_q);
         s3_a_i_d = half_floor(s2_sum_i_q);
         s3_b_r_d = sat_r.val;
         s3_b_i_d = sat_i.val;
         s3_ovf_d = sat_r.clip || sat_i.clip;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         vld_pipe_q  <= '0;
         s1_sum_r_q  <= '0;
         s1_sum_i_q  <= '0;
         s1_diff_r_q <= '0;
         s1_diff_i_q <= '0;
         s1_wr_q     <= '0;
         s1_wi_q     <= '0;
         s2_sum_r_q  <= '0;
         s2_sum_i_q  <= '0;
         s3_a_r_q    <= '0;
         s3_a_i_q    <= '0;
         s3_b_r_q    <= '0;
         s3_b_i_q    <= '0;
         s3_ovf_q    <= 1'b0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         s1_sum_r_q  <= s1_sum_r_d;
         s1_sum_i_q  <= s1_sum_i_d;
         s1_diff_r_q <= s1_diff_r_d;
         s1_diff_i_q <= s1_diff_i_d;
         s1_wr_q     <= s1_wr_d;
         s1_wi_q     <= s1_wi_d;
         s2_sum_r_q  <= s2_sum_r_d;
         s2_sum_i_q  <= s2_sum_i_d;
         s3_a_r_q    <= s3_a_r_d;
         s3_a_i_q    <= s3_a_i_d;
         s3_b_r_q    <= s3_b_r_d;
         s3_b_i_q    <= s3_b_i_d;
         s3_ovf_q    <= s3_ovf_d;
      end
   end

   assign bus.o_ready    = en;
   assign bus.o_valid    = vld_pipe_q[STAGES];
   assign bus.o_A        = cplx_pack(s3_a_r_q, s3_a_i_q);
   assign bus.o_B        = cplx_pack(s3_b_r_q, s3_b_i_q);
   assign bus.o_overflow = s3_ovf_q;
endmodule

// File: doc/ifft_butterfly.md
# ifft_butterfly

Pipelined radix-2 inverse (decimation-in-frequency, Gentleman-Sande) butterfly: the inverse-transform counterpart of the forward FFT butterfly sum. Takes two complex samples and a twiddle factor and produces o_A = (A+B)/2 and o_B = (A−B)·conj(W)/2, with the per-stage 1/2 scaling that makes a log2(N)-stage IFFT self-normalising. Sits in the IFFT datapath between the stage-ordering memory and the next butterfly rank, with a valid/ready handshake on both sides.

## Interface
- WORD_SIZE, 74: complex word width; real in [WORD_SIZE-1:HALF_SIZE], imaginary in [HALF_SIZE-1:0]
- HALF_SIZE, 37: component width, signed two's complement
- FRAC_BITS, 16: fractional bits of twiddle components (1.0 = 2^FRAC_BITS)

- i_CLK  in  1  clock, rising edge
- i_RST  in  1  synchronous, active-high reset
- i_valid  in  1  input triple valid
- o_ready  out  1  block accepts input this cycle
- i_A  in  WORD_SIZE  complex sample A
- i_B  in  WORD_SIZE  complex sample B
- i_twiddle  in  WORD_SIZE  twiddle W (non-conjugated; block conjugates internally)
- o_valid  out  1  output pair valid
- i_ready  in  1  downstream accepts output
- o_A  out  WORD_SIZE  (A+B)/2
- o_B  out  WORD_SIZE  (A−B)·conj(W)/2
- o_overflow  out  1  qualified by o_valid; a component of o_B saturated

## Operation
- Three-stage pipeline, single global enable en = !s3_valid || i_ready; o_ready = en (combinational from i_ready).
- Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
- S1: sum_r/i = A+B, diff_r/i = A−B per component, HALF_SIZE+1 bits, sign-extended; W registered alongside.
- S2: conj multiply: p_r = dr·wr + di·wi, p_i = di·wr − dr·wi, full precision (2·HALF_SIZE+3 bits).
- S3: o_A components = sum >>> 1; o_B components = p >>> (FRAC_BITS+1); arithmetic shift (floor toward −∞), no rounding.
- o_A cannot overflow. o_B components saturate to [−2^(HALF_SIZE-1), 2^(HALF_SIZE-1)−1]; o_overflow = 1 if either component clipped.
- Twiddle components valid range |wr|,|wi| ≤ 2^FRAC_BITS; outside range, result is saturated, not checked.
- Valid bits ripple with data; bubbles are not collapsed.

## Timing
- Reset: all stage valids 0, o_valid=0, o_A=o_B=0, o_overflow=0; o_ready=1 in the cycle after reset (s3_valid=0).
- Latency: 3 cycles from accepted input to o_valid with no stall; throughput 1 per cycle.
- While o_valid && !i_ready: every stage holds, o_A/o_B/o_overflow stable, o_ready=0.
- Simultaneous output and input transfer in the same cycle: legal, pipeline advances, no loss.
- i_RST mid-operation: all in-flight items dropped, outputs return to reset values next edge; no partial result emitted.
- Data registers of invalid stages may hold stale values; only valid-qualified outputs are meaningful, but o_A/o_B are zeroed by reset.

## Structure
- Package fft_pkg: WORD_SIZE, HALF_SIZE, FRAC_BITS defaults; complex pack/unpack helpers (real/imag slice); signed saturate-to-HALF_SIZE function. Shared with the forward butterfly.
- One sub-module: cplx_conj_mult_pipe (S2 multiply, one register stage, enable input), so the forward path can reuse a non-conjugating variant.
- Top holds S1 add/sub, S3 shift/saturate, valid pipeline and handshake.

## Test plan
- Identity twiddle: W=(65536,0), A=(100,0), B=(50,0) -> o_A=(75,0), o_B=(25,0), o_valid exactly 3 cycles after acceptance, o_overflow=0.
- Conjugation: W=(0,−65536), A=(30,20), B=(20,0) -> o_A=(25,10), o_B=(−10,5).
- Floor shift: W=(65536,0), A=(1,0),B=(0,0) -> o_A=(0,0), o_B=(0,0); A=(−1,0),B=(0,0) -> o_A=(−1,0), o_B=(−1,0).
- Saturation: W=(65536,65536), A=(2^36−1,2^36−1), B=(−2^36,−2^36) -> o_B=(2^36−1,0), o_overflow=1; o_A=(−1,−1).
- Backpressure: stream 6 back-to-back items, hold i_ready low 5 cycles from first o_valid -> o_ready low while stalled, outputs stable, all 6 results emerge in order, none duplicated.
- Reset mid-stream: assert i_RST with 3 items in flight -> next cycle o_valid=0, o_A=o_B=0, o_ready=1; subsequent input yields correct result after 3 cycles.
